// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes, NZCV flag generation
// and an architectural flag register; stage 1 latches operands, stage 2 drives outputs.
module alu_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       CONTROL,
    input  logic             SETFLAGS,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZEROFLAG,
    output logic             NEG,
    output logic             CARRY,
    output logic             OVF,
    output logic             ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic [3:0]       FLAGS
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_LSL   = 4'b1000,
        OP_LSR   = 4'b1001,
        OP_ASR   = 4'b1010,
        OP_NOR   = 4'b1100
    } alu_op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_ctrl;
    logic             s1_setf;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic             alu_n;
    logic             alu_z;

    assign s2_adv   = !OUT_VALID || OUT_READY;
    assign s1_adv   = !s1_valid || s2_adv;
    assign IN_READY = FLUSH || s1_adv;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
            s1_setf  <= 1'b0;
            s1_tag   <= '0;
        end else if (FLUSH) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_ctrl <= CONTROL;
                s1_setf <= SETFLAGS;
                s1_tag  <= IN_TAG;
            end
        end
    end

    always_comb begin
        sum     = {1'b0, s1_a} + {1'b0, s1_b};
        diff    = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = s1_b[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (alu_op_e'(s1_ctrl))
            OP_AND:   alu_res = s1_a & s1_b;
            OP_OR:    alu_res = s1_a | s1_b;
            OP_XOR:   alu_res = s1_a ^ s1_b;
            OP_NOR:   alu_res = ~(s1_a | s1_b);
            OP_PASSB: alu_res = s1_b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            // carry-out of A + ~B + 1 is the inverted borrow
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_LSL:   alu_res = s1_a << shamt;
            OP_LSR:   alu_res = s1_a >> shamt;
            OP_ASR:   alu_res = WIDTH'($signed(s1_a) >>> shamt);
            default:  alu_ill = 1'b1;
        endcase
        alu_n = alu_res[WIDTH-1];
        alu_z = (alu_res == '0);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            ZEROFLAG  <= 1'b0;
            NEG       <= 1'b0;
            CARRY     <= 1'b0;
            OVF       <= 1'b0;
            ILLEGAL   <= 1'b0;
            OUT_TAG   <= '0;
            FLAGS     <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (s2_adv) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                RESULT   <= alu_res;
                ZEROFLAG <= alu_z;
                NEG      <= alu_n;
                CARRY    <= alu_c;
                OVF      <= alu_v;
                ILLEGAL  <= alu_ill;
                OUT_TAG  <= s1_tag;
                if (s1_setf && !alu_ill) begin
                    FLAGS <= {alu_n, alu_z, alu_c, alu_v};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 64-bit instance with directed, backpressure, flush and
// reset scenarios, plus an 8-bit instance for the narrow-width arithmetic cases.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [3:0]  control = '0;
    logic        setflags = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        zf, neg, carry, ovf, illegal;
    logic [4:0]  out_tag;
    logic [3:0]  flags;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [3:0]  ctl8 = '0;
    logic [4:0]  in_tag8 = 5'd0;
    logic        flush8 = 1'b0;
    logic        setf8 = 1'b1;
    logic        out_ready8 = 1'b1;
    logic        out_valid8;
    logic [7:0]  result8;
    logic        zf8, neg8, carry8, ovf8, illegal8;
    logic [4:0]  out_tag8;
    logic [3:0]  flags8;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  nzcv;
        logic        ill;
        logic [4:0]  tag;
        logic [3:0]  fl;
    } item_t;

    item_t       q[$];
    logic [3:0]  mflags = 4'b0000;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rnd_ready = 1'b0;

    alu_pipe #(.WIDTH(64), .TAG_W(5)) dut (
        .CLOCK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CONTROL(control), .SETFLAGS(setflags), .IN_TAG(in_tag),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .RESULT(result), .ZEROFLAG(zf),
        .NEG(neg), .CARRY(carry), .OVF(ovf), .ILLEGAL(illegal), .OUT_TAG(out_tag), .FLAGS(flags)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
        .CLOCK(clk), .RESET_N(rst_n), .FLUSH(flush8), .IN_VALID(in_valid8), .IN_READY(in_ready8),
        .A(a8), .B(b8), .CONTROL(ctl8), .SETFLAGS(setf8), .IN_TAG(in_tag8),
        .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .RESULT(result8), .ZEROFLAG(zf8),
        .NEG(neg8), .CARRY(carry8), .OVF(ovf8), .ILLEGAL(illegal8), .OUT_TAG(out_tag8), .FLAGS(flags8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t model(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] op,
                                    input logic sf, input logic [4:0] tg, input logic [3:0] fin);
        item_t       it;
        logic [63:0] r;
        logic [64:0] w;
        logic        c, v, ill;
        logic [5:0]  sh;
        r = '0; w = '0; c = 1'b0; v = 1'b0; ill = 1'b0; sh = tb[5:0];
        case (op)
            4'b0000: r = ta & tb;
            4'b0001: r = ta | tb;
            4'b0011: r = ta ^ tb;
            4'b1100: r = ~(ta | tb);
            4'b0111: r = tb;
            4'b0010: begin
                w = 65'(ta) + 65'(tb);
                r = w[63:0];
                c = w[64];
                v = (ta[63] == tb[63]) && (r[63] != ta[63]);
            end
            4'b0110: begin
                r = ta - tb;
                c = (ta >= tb);
                v = (ta[63] != tb[63]) && (r[63] != ta[63]);
            end
            4'b1000: r = ta << sh;
            4'b1001: r = ta >> sh;
            4'b1010: begin
                r = ta >> sh;
                if (ta[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
            end
            default: ill = 1'b1;
        endcase
        it.res  = r;
        it.nzcv = {r[63], (r == 64'd0), c, v};
        it.ill  = ill;
        it.tag  = tg;
        it.fl   = (sf && !ill) ? it.nzcv : fin;
        return it;
    endfunction

    // handshakes complete at the following rising edge; everything here samples mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                check("in_ready_flush", in_ready, 1);
            end else begin
                check("in_ready", in_ready, (q.size() == 2 && !out_ready) ? 1'b0 : 1'b1);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out", out_tag, 5'h1F);
                        check("spurious_out_cnt", 1, 0);
                    end else begin
                        item_t e;
                        e = q.pop_front();
                        check("sb_tag", out_tag, e.tag);
                        check("sb_result", result, e.res);
                        check("sb_nzcv", {neg, zf, carry, ovf}, e.nzcv);
                        check("sb_illegal", illegal, e.ill);
                        check("sb_flags", flags, e.fl);
                    end
                end
                if (in_valid && in_ready) begin
                    item_t n;
                    n = model(a, b, control, setflags, in_tag, mflags);
                    mflags = n.fl;
                    q.push_back(n);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] op,
                        input logic sf, input logic [4:0] tg);
        bit got;
        got = 1'b0;
        a = ta; b = tb; control = op; setflags = sf; in_tag = tg; in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic dchk(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] op, input logic sf,
                        input logic [63:0] res, input logic [3:0] nzcv, input logic ill, input logic [3:0] fl);
        send(ta, tb, op, sf, 5'd31);
        check("lat_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("d_result", result, res);
        check("d_nzcv", {neg, zf, carry, ovf}, nzcv);
        check("d_illegal", illegal, ill);
        check("d_flags", flags, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic d8(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] op, input logic [4:0] tg,
                      input logic [7:0] res, input logic [3:0] nzcv, input logic [3:0] fl);
        a8 = ta; b8 = tb; ctl8 = op; in_tag8 = tg; in_valid8 = 1'b1;
        #1;
        check("w8_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("w8_valid", out_valid8, 1);
        check("w8_result", result8, res);
        check("w8_nzcv", {neg8, zf8, carry8, ovf8}, nzcv);
        check("w8_illegal", illegal8, 0);
        check("w8_tag", out_tag8, tg);
        check("w8_flags", flags8, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ops [11];
        logic [63:0] ra, rb;
        longint      t0;
        int          waited;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_misc", {neg, zf, carry, ovf, illegal, out_tag}, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dchk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 64'd0, 4'b0110, 1'b0, 4'b0110);
        dchk(64'h8000_0000_0000_0000, 64'd1, 4'b0110, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0, 4'b0011);
        dchk(64'd3, 64'd5, 4'b0110, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 4'b1000);
        dchk(64'h8000_0000_0000_0000, 64'h43, 4'b1010, 1'b0, 64'hF000_0000_0000_0000, 4'b1000, 1'b0, 4'b1000);
        dchk(64'd1, 64'h7F, 4'b1000, 1'b0, 64'h8000_0000_0000_0000, 4'b1000, 1'b0, 4'b1000);
        dchk(64'd5, 64'd5, 4'b1111, 1'b1, 64'd0, 4'b0100, 1'b1, 4'b1000);

        t0 = $time;
        for (int i = 0; i < 4; i++) send(64'(i * 7), 64'd9, 4'b0010, 1'b0, 5'(20 + i));
        check("throughput_cycles", 64'(($time - t0) / 10), 4);
        repeat (3) @(posedge clk);
        #1;

        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: ra = 64'h8000_0000_0000_0000;
                1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            send(ra, rb, ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), 5'(i % 10 + 1));
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 0);

        out_ready = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 5'd7);
        send(64'd3, 64'd5, 4'b0110, 1'b1, 5'd8);
        repeat (2) @(posedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_tag", out_tag, 7);
        check("stall_flags", flags, 4'b0110);
        flush = 1'b1;
        out_ready = 1'b1;
        a = 64'd1; b = 64'd1; control = 4'b0010; setflags = 1'b1; in_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_flags", flags, 4'b0110);
        mflags = q[0].fl;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("flush_no_ghost", out_valid, 0);
        dchk(64'd5, 64'd7, 4'b0010, 1'b1, 64'd12, 4'b0000, 1'b0, 4'b0000);

        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; control = 4'b0010; setflags = 1'b1; in_tag = 5'd3;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("pre_reset_flags", flags, 4'b0110);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", flags, 0);
        check("mid_rst_misc", {neg, zf, carry, ovf, illegal, out_tag}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 0);

        d8(8'hFF, 8'h01, 4'b0010, 5'd4, 8'h00, 4'b0110, 4'b0110);
        d8(8'h80, 8'h01, 4'b0110, 5'd5, 8'h7F, 4'b0011, 4'b0011);
        d8(8'h03, 8'h05, 4'b0110, 5'd6, 8'hFE, 4'b1000, 4'b1000);

        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
